// File: rtl/axi_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_wr_arb
// Brief    : Round-robin arbiter that hands one AXI write requester at a time
//            the shared RAM write port, holding the grant from arbitration
//            through the B handshake, with a sticky stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_valid,
    input  logic                     m_awvalid,
    input  logic                     m_awready,
    input  logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic                     m_wlast,
    input  logic                     m_bvalid,
    input  logic                     m_bready,
    output logic                     timeout
);

    localparam int                   c_IDX_W    = $clog2(N_REQ);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(N_REQ - 1);
    localparam logic [c_IDX_W:0]     c_N_WIDE   = (c_IDX_W + 1)'(N_REQ);
    localparam logic [N_REQ-1:0]     c_ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic                 r_w_done;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_wlast_hs;
    logic                 w_b_hs;
    logic                 w_pick_found;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [c_IDX_W:0]     w_sum;

    assign w_aw_hs    = m_awvalid & m_awready;
    assign w_w_hs     = m_wvalid & m_wready;
    assign w_wlast_hs = w_w_hs & m_wlast;
    assign w_b_hs     = m_bvalid & m_bready;

    // Scan offsets from the highest down so the smallest offset from
    // r_rr_ptr is the one left standing.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = r_rr_ptr;
        w_sum        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(i);
            if (w_sum >= c_N_WIDE) begin
                w_sum = w_sum - c_N_WIDE;
            end
            if (req[w_sum[c_IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_sum[c_IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            r_rr_ptr  <= '0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        gnt       <= c_ONE_HOT0 << w_pick_idx;
                        gnt_idx   <= w_pick_idx;
                        gnt_valid <= 1'b1;
                        r_w_done  <= 1'b0;
                        r_state   <= S_ADDR;
                    end else begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                S_ADDR: begin
                    // The last W beat may legally precede or coincide with AW.
                    if (w_wlast_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_hs) begin
                        r_state <= (r_w_done || w_wlast_hs) ? S_RESP : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_wlast_hs) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_b_hs) begin
                        r_state   <= S_IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_rr_ptr  <= (gnt_idx == c_LAST_IDX) ? '0
                                                             : gnt_idx + c_IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int                c_WD_W   = $clog2(TIMEOUT + 1);
            localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT);

            logic [c_WD_W-1:0] r_wd_cnt;
            logic [c_WD_W-1:0] w_wd_nxt;

            // Any channel progress proves the bus is alive; saturate rather than wrap.
            always_comb begin
                if ((r_state == S_IDLE) || w_aw_hs || w_w_hs || w_b_hs) begin
                    w_wd_nxt = '0;
                end else if (r_wd_cnt == c_WD_MAX) begin
                    w_wd_nxt = r_wd_cnt;
                end else begin
                    w_wd_nxt = r_wd_cnt + c_WD_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wd_cnt <= '0;
                    timeout  <= 1'b0;
                end else begin
                    r_wd_cnt <= w_wd_nxt;
                    if (w_wd_nxt == c_WD_MAX) begin
                        timeout <= 1'b1;
                    end
                end
            end
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/axi_wr_arb.md
AXI_WR_ARB -- requirements
Module: axi_wr_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of write requesters (2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, giving the watchdog limit in cycles; 0 disables the watchdog.
REQ-003 The block SHALL have these ports: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester write pending (AW valid of requester i).
- gnt  out  N_REQ  one-hot grant; selects requester AW/W/B onto the shared RAM write port.
- gnt_idx  out  $clog2(N_REQ)  index of granted requester.
- gnt_valid  out  1  a grant is held.
- m_awvalid, m_awready  in  1 each  shared AW channel handshake pair.
- m_wvalid, m_wready, m_wlast  in  1 each  shared W channel handshake and last beat.
- m_bvalid, m_bready  in  1 each  shared B channel handshake pair.
- timeout  out  1  sticky watchdog flag.

Function
REQ-004 The FSM SHALL have states IDLE, ADDR, DATA and RESP, with IDLE as the reset state.
REQ-005 In IDLE with req nonzero, the block SHALL select the first set req bit searching upward from rr_ptr modulo N_REQ.
- On the next edge: register gnt/gnt_idx, set gnt_valid=1, enter ADDR.
REQ-006 In IDLE with req==0, the block SHALL hold gnt=0, gnt_valid=0 and gnt_idx unchanged.
REQ-007 In ADDR, on m_awvalid&&m_awready, the block SHALL enter DATA, or enter RESP if w_done is set.
REQ-008 In ADDR, a W handshake with m_wlast=1 before the AW handshake SHALL set the w_done flag.
- The same rule applies when that W handshake occurs in the same cycle as the AW handshake; the FSM then enters RESP directly.
REQ-009 In DATA, a W handshake with m_wlast=1 SHALL move the FSM to RESP; W beats without wlast SHALL leave the state unchanged.
REQ-010 In RESP, a handshake m_bvalid&&m_bready SHALL, on the next edge:
- move the FSM to IDLE;
- clear gnt and gnt_valid and w_done;
- set rr_ptr = (gnt_idx+1) mod N_REQ.
REQ-011 The grant SHALL be held from grant to B handshake regardless of req; req SHALL be sampled only in IDLE.
REQ-012 Turnaround: the minimum gap SHALL be one cycle with gnt_valid=0 between consecutive grants; the grant-to-grant latency is then 1 cycle after the IDLE-to-arbitration decision.
REQ-013 rr_ptr SHALL change only on B completion, so each requester waits at most N_REQ-1 transactions.
REQ-014 Watchdog (TIMEOUT>0): the counter SHALL clear in IDLE and on any AW, W or B handshake; it SHALL increment otherwise.
- Reaching TIMEOUT sets timeout=1 (sticky until reset).
- FSM and grant are unaffected.
REQ-015 The counter SHALL saturate at TIMEOUT and not wrap.
REQ-016 gnt SHALL always be either zero or one-hot, with gnt_valid == |gnt.
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-018 Asserting rst_n=0 SHALL, immediately and asynchronously, set:
- FSM=IDLE;
- gnt=0, gnt_idx=0, gnt_valid=0;
- rr_ptr=0, w_done=0;
- watchdog count=0, timeout=0.
REQ-019 Reset asserted mid-transaction SHALL abandon the grant; after release, arbitration SHALL restart from rr_ptr=0.
REQ-020 The first arbitration SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-021 Contention: req=4'b1111 held, four single-beat transactions -> grant order 0,1,2,3,0; gnt_valid low exactly one cycle between grants.
REQ-022 Fairness: req=4'b0101 held -> grants alternate 0,2,0,2; rr_ptr after grant 2 completes = 3, next grant = 0.
REQ-023 Burst hold: requester 1 granted, awlen=7, req[1] dropped after AW -> gnt stays 4'b0010 through 8 W beats until B handshake, then clears.
REQ-024 Early W: wlast handshake occurs in ADDR before AW -> w_done=1; AW handshake moves FSM straight to RESP; same-cycle AW+wlast also goes to RESP.
REQ-025 Watchdog: TIMEOUT=16, m_bvalid held 0 in RESP -> timeout rises on cycle 16 after last handshake, stays 1; gnt unchanged.
REQ-026 Reset mid-burst: rst_n low during DATA -> gnt=0, gnt_valid=0, timeout=0 within the same cycle; after release with req=4'b1000 -> gnt=4'b1000 on the first edge.
